// File: rtl/ascon_ad_absorb.sv
// ascon_ad_absorb
// Takes the 320-bit state left by the Ascon initialisation stage and absorbs
// associated data as 64-bit rate blocks into x0. Each absorbed block is followed
// by p^b. Data is padded with 0x80 and then zeros. When the last block is a full
// 8 bytes, a separate pad block (0x80 then zeros) is absorbed with its own p^b
// pass. After the last block, x4 bit 0 is flipped for domain separation, and the
// result is presented on the output stream.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   state_valid_i/_o    state-in handshake (ready only in IDLE); state_i is x0..x4
//   no_ad_i             sampled with the state handshake; skip straight to domain separation
//   ad_valid_i/ad_ready_o, ad_data_i, ad_bytes_i, ad_last_i
//                       AD block stream; the first byte is in [63:56]
//   out_valid_o/out_ready_i, state_o
//                       absorbed state; state_o is the working state register
//   busy_o              high whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | waiting for a post-init state
// ABSORB | waiting for an AD block to XOR into x0
// PERM   | running p^b, UNROLL rounds per clock
// PAD    | absorbing the stand-alone pad block after a full last block
// DSEP   | flipping x4[0] for domain separation
// OUT    | holding the result until the consumer takes it
module ascon_ad_absorb #(
    parameter int ROUNDS_B = 6,
    parameter int UNROLL   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             state_valid_i,
    output logic             state_ready_o,
    input  logic [4:0][63:0] state_i,
    input  logic             no_ad_i,
    input  logic             ad_valid_i,
    output logic             ad_ready_o,
    input  logic [63:0]      ad_data_i,
    input  logic [3:0]       ad_bytes_i,
    input  logic             ad_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [4:0][63:0] state_o,
    output logic             busy_o
);

    if (ROUNDS_B < 1 || ROUNDS_B > 12 || UNROLL < 1 || (ROUNDS_B % UNROLL) != 0) begin : g_bad_cfg
        $error("ascon_ad_absorb: UNROLL must divide ROUNDS_B, and ROUNDS_B must be 1..12");
    end

    localparam logic [3:0] RC_START = 4'(12 - ROUNDS_B);
    localparam logic [3:0] RC_STEP  = 4'(UNROLL);

    typedef enum logic [2:0] {
        S_IDLE, S_ABSORB, S_PERM, S_PAD, S_DSEP, S_OUT
    } state_e;

    state_e          fsm_q, fsm_d;
    logic [4:0][63:0] st_q, st_d;
    logic [3:0]      rnd_q, rnd_d;
    logic            pad_q, pad_d;
    logic            last_q, last_d;

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                     input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [4:0][63:0] r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x2 = x2 ^ {56'd0, 4'hF - i, i};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        r[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        r[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return r;
    endfunction

    logic [4:0][63:0] perm_s;
    always_comb begin
        perm_s = st_q;
        for (int k = 0; k < UNROLL; k++) begin
            perm_s = ascon_round(perm_s, rnd_q + 4'(k));
        end
    end

    // Only the last block may be short; out-of-range byte counts count as a full block.
    logic [3:0]  bytes_eff;
    logic [63:0] pad_blk;
    always_comb begin
        bytes_eff = (!ad_last_i || ad_bytes_i == 4'd0 || ad_bytes_i > 4'd8) ? 4'd8 : ad_bytes_i;
        pad_blk   = '0;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < bytes_eff) begin
                pad_blk[63 - 8*j -: 8] = ad_data_i[63 - 8*j -: 8];
            end else if (4'(j) == bytes_eff) begin
                pad_blk[63 - 8*j -: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        rnd_d  = rnd_q;
        pad_d  = pad_q;
        last_d = last_q;
        state_ready_o = 1'b0;
        ad_ready_o    = 1'b0;
        out_valid_o   = 1'b0;
        unique case (fsm_q)
            S_IDLE: begin
                state_ready_o = 1'b1;
                if (state_valid_i) begin
                    st_d   = state_i;
                    pad_d  = 1'b0;
                    last_d = 1'b0;
                    fsm_d  = no_ad_i ? S_DSEP : S_ABSORB;
                end
            end
            S_ABSORB: begin
                ad_ready_o = 1'b1;
                if (ad_valid_i) begin
                    st_d[0] = st_q[0] ^ pad_blk;
                    pad_d   = ad_last_i && (bytes_eff == 4'd8);
                    last_d  = ad_last_i;
                    rnd_d   = RC_START;
                    fsm_d   = S_PERM;
                end
            end
            S_PERM: begin
                st_d  = perm_s;
                rnd_d = rnd_q + RC_STEP;
                if (rnd_q + RC_STEP == 4'd12) begin
                    if (pad_q)       fsm_d = S_PAD;
                    else if (last_q) fsm_d = S_DSEP;
                    else             fsm_d = S_ABSORB;
                end
            end
            S_PAD: begin
                st_d[0] = st_q[0] ^ 64'h8000_0000_0000_0000;
                pad_d   = 1'b0;
                rnd_d   = RC_START;
                fsm_d   = S_PERM;
            end
            S_DSEP: begin
                st_d[4][0] = ~st_q[4][0];
                fsm_d      = S_OUT;
            end
            S_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q  <= S_IDLE;
            st_q   <= '0;
            rnd_q  <= '0;
            pad_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            rnd_q  <= rnd_d;
            pad_q  <= pad_d;
            last_q <= last_d;
        end
    end

    assign state_o = st_q;
    assign busy_o  = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_ascon_ad_absorb.sv
module tb_ascon_ad_absorb;

    localparam int NDUT = 4;
    localparam int RB   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             st_valid [NDUT];
    logic             st_ready [NDUT];
    logic [4:0][63:0] st_in    [NDUT];
    logic             no_ad    [NDUT];
    logic             ad_valid [NDUT];
    logic             ad_ready [NDUT];
    logic [63:0]      ad_data  [NDUT];
    logic [3:0]       ad_bytes [NDUT];
    logic             ad_last  [NDUT];
    logic             out_valid[NDUT];
    logic             out_ready[NDUT];
    logic [4:0][63:0] st_out   [NDUT];
    logic             busy     [NDUT];

    int unrolls [NDUT] = '{1, 2, 3, 6};

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int UN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
        ascon_ad_absorb #(.ROUNDS_B(RB), .UNROLL(UN)) u_dut (
            .clk_i(clk), .rst_i(rst),
            .state_valid_i(st_valid[g]), .state_ready_o(st_ready[g]),
            .state_i(st_in[g]), .no_ad_i(no_ad[g]),
            .ad_valid_i(ad_valid[g]), .ad_ready_o(ad_ready[g]),
            .ad_data_i(ad_data[g]), .ad_bytes_i(ad_bytes[g]), .ad_last_i(ad_last[g]),
            .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
            .state_o(st_out[g]), .busy_o(busy[g])
        );
    end

    int checks = 0;
    int errors = 0;

    byte unsigned ad_q[$];

    // Ascon S-box as a 5-bit lookup, x0 is the MSB of the column.
    byte unsigned SBOX[32] = '{8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
                               8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
                               8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
                               8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17};

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [4:0][63:0] ref_perm(input logic [4:0][63:0] s, input int rounds);
        logic [4:0][63:0] t;
        logic [4:0] idx;
        logic [4:0] o;
        for (int r = 12 - rounds; r < 12; r++) begin
            s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                idx = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
                o = 5'(SBOX[idx]);
                t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
            end
            s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
            s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
            s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
            s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
            s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        end
        return s;
    endfunction

    // Ascon AD processing: append 0x80, zero-fill to 8 bytes, absorb each block, then domain-separate.
    function automatic logic [4:0][63:0] ref_absorb(input logic [4:0][63:0] s,
                                                    input byte unsigned ad[$], input int rounds);
        byte unsigned p[$];
        logic [63:0] blk;
        if (ad.size() > 0) begin
            p = ad;
            p.push_back(8'h80);
            while (p.size() % 8 != 0) p.push_back(8'h00);
            for (int b = 0; b < p.size() / 8; b++) begin
                blk = '0;
                for (int j = 0; j < 8; j++) blk = {blk[55:0], p[8*b + j]};
                s[0] = s[0] ^ blk;
                s = ref_perm(s, rounds);
            end
        end
        s[4][0] = ~s[4][0];
        return s;
    endfunction

    function automatic logic [4:0][63:0] rand_state();
        logic [4:0][63:0] s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic idle_inputs(input int k);
        st_valid[k] = 1'b0; st_in[k] = '0; no_ad[k] = 1'b0;
        ad_valid[k] = 1'b0; ad_data[k] = '0; ad_bytes[k] = '0; ad_last[k] = 1'b0;
        out_ready[k] = 1'b0;
    endtask

    // Drives one message from ad_q through instance k and reports what was observed.
    // lat = edges from the last input handshake to the first cycle with out_valid high.
    task automatic drive_msg(input int k, input logic [4:0][63:0] init,
                             input int gap_min, input int gap_max, input int stall,
                             output logic [4:0][63:0] res, output int lat,
                             output logic [63:0] x0_first, output bit stable,
                             output bit timeout, output bit back_idle);
        int n, nblk, cyc, rem, sel, idx;
        n = ad_q.size();
        nblk = (n + 7) / 8;
        timeout = 0; stable = 1; back_idle = 0; lat = 0; res = '0; x0_first = '0;
        st_valid[k] = 1'b1; st_in[k] = init; no_ad[k] = (n == 0);
        cyc = 0;
        while (!st_ready[k] && cyc < 100) begin @(posedge clk); #1; cyc++; end
        if (!st_ready[k]) begin timeout = 1; idle_inputs(k); return; end
        @(posedge clk); #1;
        st_valid[k] = 1'b0; no_ad[k] = 1'b0;
        for (int b = 0; b < nblk; b++) begin
            repeat ($urandom_range(gap_min, gap_max)) begin @(posedge clk); #1; end
            for (int j = 0; j < 8; j++) begin
                idx = 8*b + j;
                ad_data[k][63 - 8*j -: 8] = (idx < n) ? ad_q[idx] : 8'($urandom);
            end
            ad_last[k] = (b == nblk - 1);
            if (b == nblk - 1) begin
                rem = n - 8*b;
                sel = $urandom_range(0, 3);
                if (rem < 8)       ad_bytes[k] = 4'(rem);
                else if (sel == 0) ad_bytes[k] = 4'd0;
                else if (sel == 1) ad_bytes[k] = 4'($urandom_range(9, 15));
                else               ad_bytes[k] = 4'd8;
            end else begin
                ad_bytes[k] = 4'($urandom);
            end
            ad_valid[k] = 1'b1;
            cyc = 0;
            while (!ad_ready[k] && cyc < 100) begin @(posedge clk); #1; cyc++; end
            if (!ad_ready[k]) begin timeout = 1; idle_inputs(k); return; end
            @(posedge clk); #1;
            ad_valid[k] = 1'b0; ad_last[k] = 1'b0;
            if (b == 0) x0_first = st_out[k][0];
        end
        while (!out_valid[k] && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!out_valid[k]) begin timeout = 1; idle_inputs(k); return; end
        res = st_out[k];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!out_valid[k] || st_out[k] !== res || !busy[k]) stable = 0;
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        back_idle = st_ready[k] && !out_valid[k] && !busy[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (st_ready[k] !== 1'b1 || ad_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 ||
                busy[k] !== 1'b0 || st_out[k] !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: got sr=%b ar=%b ov=%b busy=%b state=%h, want 1 0 0 0 zero",
                         k, st_ready[k], ad_ready[k], out_valid[k], busy[k], st_out[k]);
            end
        end
    endtask

    task automatic test_no_ad();
        logic [4:0][63:0] res, exp_s;
        logic [63:0] x0f;
        int lat; bit st, to, bi;
        ad_q.delete();
        drive_msg(0, '0, 0, 0, 0, res, lat, x0f, st, to, bi);
        exp_s = '0; exp_s[4] = 64'h1;
        checks++;
        if (to || lat !== 1) begin
            errors++; $display("FAIL no_ad_latency: got lat=%0d timeout=%0b, want lat=1", lat, to);
        end
        checks++;
        if (res !== exp_s) begin
            errors++; $display("FAIL no_ad_state: got %h want %h", res, exp_s);
        end
        checks++;
        if (!bi) begin errors++; $display("FAIL no_ad_idle: got back_idle=0 want 1"); end
    endtask

    task automatic test_partial_block();
        logic [4:0][63:0] res, exp_s;
        logic [63:0] x0f;
        int lat; bit st, to, bi;
        ad_q = '{8'hAA, 8'hBB, 8'hCC};
        drive_msg(0, '0, 0, 0, 0, res, lat, x0f, st, to, bi);
        exp_s = ref_absorb('0, ad_q, RB);
        checks++;
        if (x0f !== 64'hAABBCC80_00000000) begin
            errors++; $display("FAIL partial_prexor: got %h want %h", x0f, 64'hAABBCC80_00000000);
        end
        checks++;
        if (to || lat !== RB + 1) begin
            errors++; $display("FAIL partial_latency: got %0d want %0d (timeout=%0b)", lat, RB + 1, to);
        end
        checks++;
        if (res !== exp_s) begin
            errors++; $display("FAIL partial_state: got %h want %h", res, exp_s);
        end
    endtask

    task automatic test_full_block_pad();
        logic [4:0][63:0] res, exp_s, init;
        logic [63:0] x0f;
        int lat; bit st, to, bi;
        ad_q.delete();
        for (int i = 0; i < 8; i++) ad_q.push_back(8'($urandom));
        init = rand_state();
        drive_msg(0, init, 0, 0, 0, res, lat, x0f, st, to, bi);
        exp_s = ref_absorb(init, ad_q, RB);
        checks++;
        if (to || lat !== 2 * (1 + RB)) begin
            errors++; $display("FAIL full_pad_latency: got %0d want %0d (timeout=%0b)", lat, 2 * (1 + RB), to);
        end
        checks++;
        if (res !== exp_s) begin
            errors++; $display("FAIL full_pad_state: got %h want %h", res, exp_s);
        end
    endtask

    task automatic test_multi_stall();
        logic [4:0][63:0] res, exp_s, init;
        logic [63:0] x0f;
        int lat; bit st, to, bi;
        ad_q.delete();
        for (int i = 0; i < 20; i++) ad_q.push_back(8'($urandom));
        init = rand_state();
        drive_msg(0, init, 1, 4, 5, res, lat, x0f, st, to, bi);
        exp_s = ref_absorb(init, ad_q, RB);
        checks++;
        if (to || res !== exp_s) begin
            errors++; $display("FAIL multi_state: got %h want %h (timeout=%0b)", res, exp_s, to);
        end
        checks++;
        if (!st) begin errors++; $display("FAIL multi_stall_hold: got stable=0 want 1"); end
        checks++;
        if (!bi) begin errors++; $display("FAIL multi_back_idle: got 0 want 1"); end
    endtask

    task automatic test_reset_in_perm();
        logic [4:0][63:0] init, res, exp_s;
        logic [63:0] x0f;
        int cyc, lat; bit st, to, bi;
        init = rand_state();
        st_valid[0] = 1'b1; st_in[0] = init; no_ad[0] = 1'b0;
        @(posedge clk); #1;
        st_valid[0] = 1'b0;
        ad_data[0] = {$urandom, $urandom}; ad_bytes[0] = 4'd5; ad_last[0] = 1'b1; ad_valid[0] = 1'b1;
        cyc = 0;
        while (!ad_ready[0] && cyc < 20) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        ad_valid[0] = 1'b0; ad_last[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy[0] !== 1'b1 || ad_ready[0] !== 1'b0) begin
            errors++; $display("FAIL perm_busy: got busy=%b ad_ready=%b want 1 0", busy[0], ad_ready[0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (st_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || st_out[0] !== '0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got sr=%b ov=%b busy=%b state=%h want 1 0 0 zero",
                     st_ready[0], out_valid[0], busy[0], st_out[0]);
        end
        ad_q.delete();
        for (int i = 0; i < 11; i++) ad_q.push_back(8'($urandom));
        init = rand_state();
        drive_msg(0, init, 0, 1, 0, res, lat, x0f, st, to, bi);
        exp_s = ref_absorb(init, ad_q, RB);
        checks++;
        if (to || res !== exp_s) begin
            errors++; $display("FAIL after_reset_state: got %h want %h (timeout=%0b)", res, exp_s, to);
        end
    endtask

    task automatic test_unroll_sweep();
        logic [4:0][63:0] res, exp_s, init;
        logic [63:0] x0f;
        int lat, len; bit st, to, bi;
        for (int k = 0; k < NDUT; k++) begin
            for (int m = 0; m < 6; m++) begin
                len = (m == 0) ? 0 : (m == 1) ? 40 : $urandom_range(0, 40);
                ad_q.delete();
                for (int i = 0; i < len; i++) ad_q.push_back(8'($urandom));
                init = rand_state();
                drive_msg(k, init, 0, 2, $urandom_range(0, 3), res, lat, x0f, st, to, bi);
                exp_s = ref_absorb(init, ad_q, RB);
                checks++;
                if (to || res !== exp_s || !st) begin
                    errors++;
                    $display("FAIL sweep u=%0d len=%0d: got %h want %h (timeout=%0b stable=%0b)",
                             unrolls[k], len, res, exp_s, to, st);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) idle_inputs(k);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_no_ad();
        test_partial_block();
        test_full_block_pad();
        test_multi_stall();
        test_reset_in_perm();
        test_unroll_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
